// File: rtl/pe_add_pkg.sv
// Shared definitions for the pe_add_sched adder-sharing controller.
package pe_add_pkg;

   localparam int WORD_W = 64;
   localparam int PERF_W = 32;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

endpackage

// File: rtl/adder64.sv
// Plain 64-bit combinational adder with carry in and carry out.
module adder64 (
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic        cin,
   output logic [63:0] sum,
   output logic        cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {64'd0, cin};

endmodule

// File: rtl/pe_rr_arb.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping at NREQ.
module pe_rr_arb #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  idx,
   output logic            any
);

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         int j;
         j = int'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!any && req[j]) begin
            any    = 1'b1;
            idx    = IDW'(j);
            gnt[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pe_add_sched.sv
// Shares one adder64 among NREQ requesters with round-robin grants and multi-beat carry chaining.
// Optional perf counters (perf_busy, perf_stall) are enabled by defining PE_ADD_SCHED_PERF_EN.
module pe_add_sched
   import pe_add_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*WORD_W-1:0]   req_a,
   input  logic [NREQ*WORD_W-1:0]   req_b,
   input  logic [NREQ-1:0]          req_cin,
   input  logic [NREQ-1:0]          req_last,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [WORD_W-1:0]        res_sum,
   output logic                     res_cout,
   output logic [IDW-1:0]           res_id,
   output logic                     res_last
`ifdef PE_ADD_SCHED_PERF_EN
   ,
   output logic [PERF_W-1:0]        perf_busy,
   output logic [PERF_W-1:0]        perf_stall
`endif
);

   state_t            state;
   logic [IDW-1:0]    owner;
   logic [IDW-1:0]    ptr;
   logic              carry;

   logic [NREQ-1:0]   arb_gnt;
   logic [IDW-1:0]    arb_idx;
   logic              arb_any;

   logic [IDW-1:0]    g;
   logic              out_free;
   logic              accept;
   logic [WORD_W-1:0] op_a;
   logic [WORD_W-1:0] op_b;
   logic              add_cin;
   logic [WORD_W-1:0] add_sum;
   logic              add_cout;
   logic              beat_last;
   logic [IDW-1:0]    next_ptr;

   pe_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req (req_valid),
      .ptr (ptr),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   // The output stage can refill in the same cycle it drains, so ready only waits on a stalled result.
   always_comb begin
      out_free  = !res_valid || res_ready;
      g         = (state == ST_LOCKED) ? owner : arb_idx;
      req_ready = '0;
      if (out_free) begin
         if (state == ST_LOCKED) req_ready[owner] = 1'b1;
         else                    req_ready = arb_gnt;
      end
      accept    = |(req_ready & req_valid);
      op_a      = req_a[int'(g)*WORD_W +: WORD_W];
      op_b      = req_b[int'(g)*WORD_W +: WORD_W];
      add_cin   = (state == ST_LOCKED) ? carry : req_cin[g];
      beat_last = req_last[g];
      next_ptr  = (g == IDW'(NREQ-1)) ? '0 : g + 1'b1;
   end

   adder64 u_add (
      .a    (op_a),
      .b    (op_b),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         owner     <= '0;
         ptr       <= '0;
         carry     <= 1'b0;
         res_valid <= 1'b0;
         res_sum   <= '0;
         res_cout  <= 1'b0;
         res_id    <= '0;
         res_last  <= 1'b0;
      end else if (accept) begin
         res_valid <= 1'b1;
         res_sum   <= add_sum;
         res_cout  <= add_cout;
         res_id    <= g;
         res_last  <= beat_last;
         if (beat_last) begin
            state <= ST_IDLE;
            carry <= 1'b0;
            ptr   <= next_ptr;
         end else begin
            state <= ST_LOCKED;
            owner <= g;
            carry <= add_cout;
         end
      end else if (res_ready) begin
         res_valid <= 1'b0;
      end
   end

`ifdef PE_ADD_SCHED_PERF_EN
   // Saturating counters so long runs never wrap back to small values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_busy  <= '0;
         perf_stall <= '0;
      end else begin
         if (accept && perf_busy != '1)
            perf_busy <= perf_busy + 1'b1;
         if (|req_valid && !accept && perf_stall != '1)
            perf_stall <= perf_stall + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pe_add_sched.sv
// Directed and randomized checks of pe_add_sched against a behavioural reference model.
module tb_pe_add_sched;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*64-1:0]   req_a;
   logic [NREQ*64-1:0]   req_b;
   logic [NREQ-1:0]      req_cin;
   logic [NREQ-1:0]      req_last;
   logic                 res_valid;
   logic                 res_ready;
   logic [63:0]          res_sum;
   logic                 res_cout;
   logic [IDW-1:0]       res_id;
   logic                 res_last;

   int n_checks = 0;
   int n_fail   = 0;

   pe_add_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .req_last  (req_last),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_sum   (res_sum),
      .res_cout  (res_cout),
      .res_id    (res_id),
      .res_last  (res_last)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_cin   = '0;
      req_last  = '0;
      res_ready = 1'b1;
   endtask

   task automatic set_beat(input int i, input logic [63:0] a, input logic [63:0] b,
                           input logic cin, input logic last);
      req_valid[i]        = 1'b1;
      req_a[64*i +: 64]   = a;
      req_b[64*i +: 64]   = b;
      req_cin[i]          = cin;
      req_last[i]         = last;
   endtask

   task automatic do_reset;
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset;
      clear_inputs();
      rst = 1'b1;
      #3;
      n_checks++;
      if ({res_valid, res_sum, res_cout, res_id, res_last} !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_outputs got v=%0b sum=%h c=%0b id=%0d l=%0b exp all 0",
                  res_valid, res_sum, res_cout, res_id, res_last);
      end
      n_checks++;
      if (req_ready !== 4'b0000) begin
         n_fail++;
         $display("[TB] FAIL reset_ready got %b exp 0000", req_ready);
      end
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_single_beat;
      clear_inputs();
      set_beat(0, 64'h5, 64'h3, 1'b1, 1'b1);
      #1;
      n_checks++;
      if (req_ready !== 4'b0001) begin
         n_fail++;
         $display("[TB] FAIL single_ready got %b exp 0001", req_ready);
      end
      tick();
      clear_inputs();
      n_checks++;
      if ({res_valid, res_sum, res_cout, res_id, res_last} !== {1'b1, 64'h9, 1'b0, 2'd0, 1'b1}) begin
         n_fail++;
         $display("[TB] FAIL single_result got v=%0b sum=%h c=%0b id=%0d l=%0b exp v=1 sum=9 c=0 id=0 l=1",
                  res_valid, res_sum, res_cout, res_id, res_last);
      end
      tick();
      n_checks++;
      if (res_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL single_drain got %0b exp 0", res_valid);
      end
   endtask

   task automatic test_chain;
      clear_inputs();
      set_beat(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
      #1;
      n_checks++;
      if (req_ready !== 4'b0010) begin
         n_fail++;
         $display("[TB] FAIL chain_ready got %b exp 0010", req_ready);
      end
      tick();
      set_beat(1, 64'h0, 64'h0, 1'b0, 1'b1);
      n_checks++;
      if ({res_valid, res_sum, res_cout, res_id, res_last} !== {1'b1, 64'h0, 1'b1, 2'd1, 1'b0}) begin
         n_fail++;
         $display("[TB] FAIL chain_beat0 got v=%0b sum=%h c=%0b id=%0d l=%0b exp v=1 sum=0 c=1 id=1 l=0",
                  res_valid, res_sum, res_cout, res_id, res_last);
      end
      tick();
      clear_inputs();
      n_checks++;
      if ({res_valid, res_sum, res_cout, res_id, res_last} !== {1'b1, 64'h1, 1'b0, 2'd1, 1'b1}) begin
         n_fail++;
         $display("[TB] FAIL chain_beat1 got v=%0b sum=%h c=%0b id=%0d l=%0b exp v=1 sum=1 c=0 id=1 l=1",
                  res_valid, res_sum, res_cout, res_id, res_last);
      end
      tick();
   endtask

   task automatic test_round_robin;
      do_reset();
      for (int i = 0; i < 3; i++) set_beat(i, 64'(i), 64'h0, 1'b0, 1'b1);
      for (int k = 0; k < 6; k++) begin
         tick();
         n_checks++;
         if (res_valid !== 1'b1 || res_id !== IDW'(k % 3) || res_sum !== 64'(k % 3)) begin
            n_fail++;
            $display("[TB] FAIL rr_seq[%0d] got v=%0b id=%0d sum=%h exp v=1 id=%0d sum=%0d",
                     k, res_valid, res_id, res_sum, k % 3, k % 3);
         end
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_lock;
      do_reset();
      set_beat(3, 64'd7, 64'd8, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         set_beat(0, 64'd10, 64'd20, 1'b0, (k == 2));
         #1;
         n_checks++;
         if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("[TB] FAIL lock_ready[%0d] got %b exp 0001", k, req_ready);
         end
         tick();
      end
      req_valid[0] = 1'b0;
      #1;
      n_checks++;
      if (req_ready !== 4'b1000 || res_id !== 2'd0 || res_last !== 1'b1 || res_sum !== 64'd30) begin
         n_fail++;
         $display("[TB] FAIL lock_release got ready=%b id=%0d l=%0b sum=%0d exp ready=1000 id=0 l=1 sum=30",
                  req_ready, res_id, res_last, res_sum);
      end
      tick();
      clear_inputs();
      n_checks++;
      if (res_valid !== 1'b1 || res_id !== 2'd3 || res_sum !== 64'd15) begin
         n_fail++;
         $display("[TB] FAIL lock_follow got v=%0b id=%0d sum=%0d exp v=1 id=3 sum=15",
                  res_valid, res_id, res_sum);
      end
      tick();
   endtask

   task automatic test_backpressure;
      clear_inputs();
      set_beat(2, 64'd100, 64'd1, 1'b0, 1'b1);
      tick();
      clear_inputs();
      res_ready = 1'b0;
      set_beat(1, 64'd50, 64'd50, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         #1;
         n_checks++;
         if (req_ready !== 4'b0000 || res_valid !== 1'b1 || res_sum !== 64'd101 || res_id !== 2'd2) begin
            n_fail++;
            $display("[TB] FAIL bp_hold[%0d] got ready=%b v=%0b sum=%0d id=%0d exp ready=0000 v=1 sum=101 id=2",
                     k, req_ready, res_valid, res_sum, res_id);
         end
         tick();
      end
      res_ready = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 4'b0010) begin
         n_fail++;
         $display("[TB] FAIL bp_release got %b exp 0010", req_ready);
      end
      tick();
      clear_inputs();
      n_checks++;
      if (res_valid !== 1'b1 || res_sum !== 64'd100 || res_id !== 2'd1) begin
         n_fail++;
         $display("[TB] FAIL bp_next got v=%0b sum=%0d id=%0d exp v=1 sum=100 id=1",
                  res_valid, res_sum, res_id);
      end
      tick();
   endtask

   task automatic test_reset_mid_chain;
      clear_inputs();
      set_beat(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
      tick();
      clear_inputs();
      rst = 1'b1;
      #2;
      n_checks++;
      if ({res_valid, res_sum, res_cout, res_id, res_last, req_ready} !== '0) begin
         n_fail++;
         $display("[TB] FAIL midrst_outputs got v=%0b sum=%h c=%0b id=%0d l=%0b ready=%b exp all 0",
                  res_valid, res_sum, res_cout, res_id, res_last, req_ready);
      end
      tick();
      rst = 1'b0;
      #1;
      set_beat(0, 64'd5, 64'd6, 1'b0, 1'b1);
      #1;
      n_checks++;
      if (req_ready !== 4'b0001) begin
         n_fail++;
         $display("[TB] FAIL midrst_idle got ready=%b exp 0001", req_ready);
      end
      tick();
      clear_inputs();
      n_checks++;
      if (res_valid !== 1'b1 || res_sum !== 64'd11 || res_cout !== 1'b0 || res_id !== 2'd0) begin
         n_fail++;
         $display("[TB] FAIL midrst_carry got v=%0b sum=%0d c=%0b id=%0d exp v=1 sum=11 c=0 id=0",
                  res_valid, res_sum, res_cout, res_id);
      end
      tick();
   endtask

   // Reference model: tracks who holds the adder and what the result register should show.
   task automatic test_random;
      bit          m_locked = 0;
      int          m_owner  = 0;
      int          m_ptr    = 0;
      bit          m_carry  = 0;
      bit          m_rv     = 0;
      logic [63:0] m_sum    = '0;
      bit          m_cout   = 0;
      int          m_id     = 0;
      bit          m_last   = 0;
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         int              g;
         bit              free;
         bit              acc;
         bit              cin;
         logic [NREQ-1:0] exp_ready;
         logic [64:0]     full;
         logic [63:0]     a;
         logic [63:0]     b;
         for (int i = 0; i < NREQ; i++) begin
            a = {$urandom, $urandom};
            if ($urandom_range(3) == 0) a = '1;
            b = 64'($urandom_range(3));
            req_valid[i]      = ($urandom_range(1) == 1);
            req_a[64*i +: 64] = a;
            req_b[64*i +: 64] = b;
            req_cin[i]        = ($urandom_range(1) == 1);
            req_last[i]       = ($urandom_range(1) == 1);
         end
         res_ready = ($urandom_range(3) != 0);
         #1;
         g = -1;
         if (m_locked) g = m_owner;
         else
            for (int k = 0; k < NREQ; k++)
               if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
         free      = !m_rv || res_ready;
         exp_ready = '0;
         if (g >= 0 && free) exp_ready[g] = 1'b1;
         acc = (g >= 0) && free && req_valid[g];
         n_checks++;
         if (req_ready !== exp_ready) begin
            n_fail++;
            $display("[TB] FAIL rand_ready[%0d] got %b exp %b", cyc, req_ready, exp_ready);
         end
         if (acc) begin
            cin    = m_locked ? m_carry : req_cin[g];
            full   = {1'b0, req_a[64*g +: 64]} + {1'b0, req_b[64*g +: 64]} + 65'(cin);
            m_rv   = 1;
            m_sum  = full[63:0];
            m_cout = full[64];
            m_id   = g;
            m_last = req_last[g];
            if (req_last[g]) begin
               m_locked = 0;
               m_carry  = 0;
               m_ptr    = (g + 1) % NREQ;
            end else begin
               m_locked = 1;
               m_owner  = g;
               m_carry  = full[64];
            end
         end else if (res_ready) begin
            m_rv = 0;
         end
         tick();
         n_checks++;
         if (res_valid !== m_rv ||
             (m_rv && {res_sum, res_cout, res_id, res_last} !== {m_sum, m_cout, IDW'(m_id), m_last})) begin
            n_fail++;
            $display("[TB] FAIL rand_result[%0d] got v=%0b sum=%h c=%0b id=%0d l=%0b exp v=%0b sum=%h c=%0b id=%0d l=%0b",
                     cyc, res_valid, res_sum, res_cout, res_id, res_last, m_rv, m_sum, m_cout, m_id, m_last);
         end
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      rst = 1'b0;
      #2;
      test_reset();
      test_single_beat();
      test_chain();
      test_round_robin();
      test_lock();
      test_backpressure();
      test_reset_mid_chain();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got timeout exp completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
